mult_div_seq: RTL and testbench

Multicycle sequencer for the CPU's multiply/divide resource. It accepts a signed `mult` or `div` request from the control unit, iterates a shift-add multiplier or a restoring divider over 32 cycles, and holds the 64-bit result in the HI/LO registers. HI/LO feed the register-file write-data mux. While busy, the control unit stalls in a wait state until `done` pulses.

---
 rtl/mult_div_seq.sv | 141 ++++++++++++++
 tb/tb_mult_div_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_seq.sv
// Signed 32-step shift-add multiplier / restoring divider feeding HI/LO; result 33 cycles after accept (1 for div-by-zero).
// No backpressure: start is sampled only in IDLE and ignored while busy, so the caller stalls until done.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             is_div, dz, neg_res, neg_rem;
  logic [W2-1:0]    acc, mcand;
  logic [WIDTH:0]   mplier, dvsr, rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             last;
  logic             unused_rem_msb;

  // 33-bit magnitudes so that |0x80000000| is exact
  assign a_ext  = {a[WIDTH-1], a};
  assign b_ext  = {b[WIDTH-1], b};
  assign a_mag  = a[WIDTH-1] ? -a_ext : a_ext;
  assign b_mag  = b[WIDTH-1] ? -b_ext : b_ext;

  assign rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign trial  = {1'b0, rem_sh} - {1'b0, dvsr};
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign busy   = (state != IDLE);

  // The partial remainder is always below the divisor (<= 2^31), so its top bit stays clear
  assign unused_rem_msb = rem[WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (!op)            state_nxt = MULT;
          else if (b == '0)   state_nxt = FINISH;
          else                state_nxt = DIV;
        end
      end
      MULT:    if (last) state_nxt = FINISH;
      DIV:     if (last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      dz       <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      dvsr     <= '0;
      rem      <= '0;
      quo      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div  <= op;
            dz      <= op && (b == '0);
            neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem <= a[WIDTH-1];
            cnt     <= '0;
            acc     <= '0;
            mcand   <= {{(WIDTH-1){1'b0}}, a_mag};
            mplier  <= b_mag;
            dvsr    <= b_mag;
            rem     <= '0;
            quo     <= a_mag[WIDTH-1:0];
          end
        end
        MULT: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        DIV: begin
          if (!trial[WIDTH+1]) begin
            rem <= trial[WIDTH:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CNT_W'(1);
        end
        FINISH: begin
          done <= 1'b1;
          if (dz) begin
            div_zero <= 1'b1;
          end else if (is_div) begin
            lo <= neg_res ? -quo : quo;
            hi <= neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          end else begin
            {hi, lo} <= neg_res ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Randomised and directed bench for mult_div_seq against a plain-arithmetic reference of signed mult/div on HI/LO.
module tb_mult_div_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_hi, model_lo;
  logic [31:0] exp_hi, exp_lo;
  logic        exp_dz;
  int          exp_lat;

  mult_div_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  // Reference: signed 64-bit arithmetic; division truncates toward zero, remainder follows dividend
  task automatic model_op(input bit opx, input logic [31:0] ax, input logic [31:0] bx);
    longint sa, sb, p, q, r;
    sa = longint'($signed(ax));
    sb = longint'($signed(bx));
    if (!opx) begin
      p = sa * sb;
      exp_hi = p[63:32]; exp_lo = p[31:0]; exp_dz = 1'b0; exp_lat = 33;
    end else if (bx == 32'd0) begin
      exp_hi = model_hi; exp_lo = model_lo; exp_dz = 1'b1; exp_lat = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      exp_hi = r[31:0]; exp_lo = q[31:0]; exp_dz = 1'b0; exp_lat = 33;
    end
  endtask

  // Call at a negedge; returns #1 after the accepting edge with inputs scrambled
  task automatic start_op(input bit opx, input logic [31:0] ax, input logic [31:0] bx);
    model_op(opx, ax, bx);
    start = 1'b1; op = opx; a = ax; b = bx;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
    chk("busy_rise", {63'd0, busy}, 64'd1);
  endtask

  // Returns at the negedge of the done cycle
  task automatic wait_check(input string tag, input bit poke);
    int n, nbusy;
    n = 0; nbusy = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      if (busy) nbusy++;
      if (poke && (n == 5 || n == 20)) begin
        start = 1'b1; op = 1'($urandom); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_lat"},   64'(n),     64'(exp_lat));
    chk({tag, "_busyn"}, 64'(nbusy), 64'(exp_lat));
    chk({tag, "_busy0"}, {63'd0, busy}, 64'd0);
    chk({tag, "_dz"},    {63'd0, div_zero}, {63'd0, exp_dz});
    chk({tag, "_hi"},    {32'd0, hi}, {32'd0, exp_hi});
    chk({tag, "_lo"},    {32'd0, lo}, {32'd0, exp_lo});
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  task automatic do_op(input string tag, input bit opx, input logic [31:0] ax, input logic [31:0] bx, input bit poke);
    @(negedge clk);
    chk("done_single", {63'd0, done}, 64'd0);
    start_op(opx, ax, bx);
    wait_check(tag, poke);
  endtask

  initial begin
    bit saw_done;
    reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    model_hi = '0; model_lo = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dz",   {63'd0, div_zero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;

    do_op("m7x-3",  1'b0, 32'd7,         32'hFFFF_FFFD, 1'b0);
    chk("m7x-3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("mminsq", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("mminsq_const", {hi, lo}, 64'h4000_0000_0000_0000);
    do_op("mm1sq",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("d-7/2",  1'b1, 32'hFFFF_FFF9, 32'd2,         1'b0);
    chk("d-7/2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("dovf",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("m5x6",   1'b0, 32'd5,         32'd6,         1'b0);
    do_op("dzero",  1'b1, 32'd9,         32'd0,         1'b0);
    chk("dzero_const", {hi, lo}, 64'd30);

    do_op("poke",   1'b0, 32'd1234,      32'hFFFF_FF00, 1'b1);
    // back-to-back: new start driven during the done cycle
    start_op(1'b0, 32'h0001_0003, 32'h0002_0005);
    wait_check("b2b", 1'b0);

    @(negedge clk);
    start_op(1'b1, 32'd1_000_000, 32'd7);
    repeat (16) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rmid_busy", {63'd0, busy}, 64'd0);
    chk("rmid_hilo", {hi, lo}, 64'd0);
    model_hi = '0; model_lo = '0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b1;
      if (done) saw_done = 1'b1;
    end
    chk("rmid_nodone", {63'd0, saw_done}, 64'd0);
    do_op("m3x4",   1'b0, 32'd3, 32'd4, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      bit ro;
      ro = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 100));
        4: rb = -32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op("rnd", ro, ra, rb, 1'b0);
    end

    @(negedge clk);
    chk("done_single", {63'd0, done}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
